// File: rtl/aes128_iter_core.sv
// Round-folded AES-128 encryption core: ROUNDS_PER_CYCLE round/key stages are
// reused across cycles, with valid/ready handshakes on both sides.
module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int         ITERS = 10 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] RPC   = 4'(ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 10 || ITERS * ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] s_nxt, k_nxt;
  logic         load;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Derives round key r+1 from round key r.
  function automatic logic [127:0] gen_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rcon(r), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] full_round(input logic [127:0] s, input logic [127:0] k);
    return mix_columns(shift_rows(sub_bytes(s))) ^ k;
  endfunction

  function automatic logic [127:0] last_round(input logic [127:0] s, input logic [127:0] k);
    return shift_rows(sub_bytes(s)) ^ k;
  endfunction

  always_comb begin : round_chain
    logic [127:0] s;
    logic [127:0] k;
    logic [3:0]   r;
    s = state_q;
    k = key_q;
    r = rnd_q;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      r = rnd_q + 4'(i);
      k = gen_key(k, r);
      s = (r == 4'd9) ? last_round(s, k) : full_round(s, k);
    end
    s_nxt = s;
    k_nxt = k;
  end

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    key_d     = key_q;
    rnd_d     = rnd_q;
    dout_d    = dout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    unique case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      BUSY: begin
        busy    = 1'b1;
        state_d = s_nxt;
        key_d   = k_nxt;
        rnd_d   = rnd_q + RPC;
        if (rnd_q + RPC == 4'd10) begin
          dout_d = s_nxt;
          st_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    // A DONE-state handshake with a pending block reloads directly, skipping IDLE.
    if (load) begin
      state_d = data_in ^ key_in;
      key_d   = key_in;
      rnd_d   = 4'd0;
      st_d    = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      dout_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: four instances (1/2/5/10 rounds per cycle) share
// stimulus and are checked against a byte-level AES reference model.
module tb_aes128_iter_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;

  logic         ir [4];
  logic         ov [4];
  logic         bz [4];
  logic [127:0] dq [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes128_iter_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .data_in(data_in),
    .key_in(key_in), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dq[0]), .busy(bz[0]));
  aes128_iter_core #(.ROUNDS_PER_CYCLE(2)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .data_in(data_in),
    .key_in(key_in), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dq[1]), .busy(bz[1]));
  aes128_iter_core #(.ROUNDS_PER_CYCLE(5)) u_r5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .data_in(data_in),
    .key_in(key_in), .out_valid(ov[2]), .out_ready(out_ready), .data_out(dq[2]), .busy(bz[2]));
  aes128_iter_core #(.ROUNDS_PER_CYCLE(10)) u_r10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .data_in(data_in),
    .key_in(key_in), .out_valid(ov[3]), .out_ready(out_ready), .data_out(dq[3]), .busy(bz[3]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 10;
      1:       return 5;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking the generator 3 alongside its inverse.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] t0, t1, t2, t3, tmp, rc, a0, a1, a2, a3, tot;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      t0 = w[i-4]; t1 = w[i-3]; t2 = w[i-2]; t3 = w[i-1];
      if (i % 16 == 0) begin
        tmp = t0;
        t0 = sb[t1] ^ rc; t1 = sb[t2]; t2 = sb[t3]; t3 = sb[tmp];
        rc = xt(rc);
      end
      w[i] = w[i-16] ^ t0; w[i+1] = w[i-15] ^ t1;
      w[i+2] = w[i-14] ^ t2; w[i+3] = w[i-13] ^ t3;
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      s = t;
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          tot = a0 ^ a1 ^ a2 ^ a3;
          s[4*c]   = a0 ^ tot ^ xt(a0 ^ a1);
          s[4*c+1] = a1 ^ tot ^ xt(a1 ^ a2);
          s[4*c+2] = a2 ^ tot ^ xt(a2 ^ a3);
          s[4*c+3] = a3 ^ tot ^ xt(a3 ^ a0);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rd+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One block into every instance; checks latency and ciphertext, then handshakes.
  task automatic run_all(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e,
                         input bit scramble, input string tag);
    int first [4];
    int cyc;
    int bcnt;
    data_in = p; key_in = k; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) first[i] = -1;
    bcnt = bz[0] ? 1 : 0;
    cyc  = 0;
    while (cyc < 15 && first[0] < 0) begin
      if (scramble) begin
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      step();
      cyc++;
      for (int i = 0; i < 4; i++) if (ov[i] && first[i] < 0) first[i] = cyc;
      if (!ov[0] && bz[0]) bcnt++;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_lat_r%0d", tag, 10 / lat_of(i)), 128'(first[i]), 128'(lat_of(i)));
      chk($sformatf("%s_ct_r%0d", tag, 10 / lat_of(i)), dq[i], e);
    end
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_clear"}, 128'(ov[0]), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] vk [2];
    logic [127:0] vp [2];
    logic [127:0] ve [2];
    logic [127:0] expq [$];
    logic [127:0] rk, rp;
    int idx, nout, cyc, last_acc, ovcnt;
    bit acc;

    init_sbox();

    // Reset state of every instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_in_ready_%0d", i), 128'(ir[i]), 128'd1);
      chk($sformatf("rst_out_valid_%0d", i), 128'(ov[i]), 128'd0);
      chk($sformatf("rst_busy_%0d", i), 128'(bz[i]), 128'd0);
      chk($sformatf("rst_data_out_%0d", i), dq[i], 128'd0);
    end

    // FIPS-197 C.1 with inputs scrambled after accept, then App. B at all rates
    run_all(C1_KEY, C1_PT, C1_CT, 1'b1, "c1");
    run_all(B_KEY, B_PT, B_CT, 1'b0, "appb");

    // Backpressure: hold out_ready low with a pending block
    do_reset();
    data_in = B_PT; key_in = B_KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (cyc < 15 && !ov[0]) begin step(); cyc++; end
    chk("bp_first_valid", 128'(ov[0]), 128'd1);
    for (int i = 0; i < 7; i++) begin
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready_low", 128'(ir[0]), 128'd0);
      step();
      chk("bp_out_valid_held", 128'(ov[0]), 128'd1);
      chk("bp_data_held", dq[0], B_CT);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ov", 128'(ov[0]), 128'd0);
    chk("bp_release_idle", 128'(ir[0]), 128'd1);
    run_all(C1_KEY, C1_PT, C1_CT, 1'b0, "bp_next");

    // Back-to-back with out_ready and in_valid held high
    do_reset();
    vk[0] = C1_KEY; vp[0] = C1_PT; ve[0] = C1_CT;
    vk[1] = B_KEY;  vp[1] = B_PT;  ve[1] = B_CT;
    idx = 0; nout = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1; in_valid = 1'b1;
    data_in = vp[0]; key_in = vk[0];
    while (nout < 5 && cyc < 100) begin
      #1;
      acc = ir[0];
      if (acc) begin
        if (last_acc >= 0) begin
          chk("b2b_spacing", 128'(cyc - last_acc), 128'd11);
          chk("b2b_ready_in_done", 128'(ov[0]), 128'd1);
        end
        expq.push_back(ve[idx]);
        last_acc = cyc;
      end
      step();
      cyc++;
      if (acc) begin
        idx = 1 - idx;
        data_in = vp[idx]; key_in = vk[idx];
      end
      if (ov[0]) begin
        if (expq.size() > 0) chk("b2b_ct", dq[0], expq.pop_front());
        else chk("b2b_unexpected_out", 128'(ov[0]), 128'd0);
        nout++;
      end
    end
    chk("b2b_count", 128'(nout), 128'd5);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset during BUSY discards the block
    do_reset();
    data_in = C1_PT; key_in = C1_KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("mid_busy_before_rst", 128'(bz[0]), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_in_ready", 128'(ir[0]), 128'd1);
    chk("mid_out_valid", 128'(ov[0]), 128'd0);
    chk("mid_busy", 128'(bz[0]), 128'd0);
    chk("mid_data_out", dq[0], 128'd0);
    ovcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ov[0]) ovcnt++;
    end
    chk("mid_no_output", 128'(ovcnt), 128'd0);
    run_all(C1_KEY, C1_PT, C1_CT, 1'b0, "mid_after");

    // Random blocks against the reference model
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_all(rk, rp, ref_aes(rk, rp), 1'b1, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
